micro_sequencer: RTL and testbench

- Control unit that sits directly upstream of the datapath top level.
- Holds a writable control store and the microprogram counter (MPC).
- Each clock it issues one 28-bit microinstruction on `mir`, which the datapath consumes.
- Next-address selection uses the Mic-style JAMN/JAMZ/JMPC rules, driven by ALU flags and the MBR byte returned from the datapath.

---
 rtl/micro_sequencer.sv | 170 +++++++++++++++++
 tb/tb_micro_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//
// Microprogram control unit sitting directly upstream of the datapath. It
// owns a writable control store and the microprogram counter (MPC), and
// issues one 28-bit microinstruction per clock on `mir` while running.
// Next-address selection follows the Mic-style JAMN/JAMZ/JMPC rules using
// the ALU flags and the MBR low byte returned by the datapath.
//
// Ports
//   clock      in   system clock, rising-edge active
//   reset_n    in   asynchronous active-low reset
//   start      in   begin / restart at START_ADDR (honoured in IDLE/HALT)
//   flag_n     in   ALU negative flag for the word currently on `mir`
//   flag_z     in   ALU zero flag for the word currently on `mir`
//   mbr_byte   in   MBR low byte, OR-ed into the target when jmpc is set
//   cs_we      in   control-store write enable (honoured in IDLE/HALT)
//   cs_waddr   in   control-store write address
//   cs_wdata   in   41-bit control-store word
//   mir        out  microinstruction to the datapath (zero unless running)
//   mpc        out  address of the word currently held in the MIR
//   running    out  high in RUN
//   halted     out  high in HALT
//   ucount     out  microinstructions issued since reset (wrapping)
//
// Control-store word: {halt[40], next_addr[39:31], jmpc[30], jamn[29],
//                      jamz[28], datapath[27:0]}
// ---------------------------------------------------------------------------
module micro_sequencer #(
  parameter int ADDR_W     = 9,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              flag_n,
  input  logic              flag_z,
  input  logic [7:0]        mbr_byte,
  input  logic              cs_we,
  input  logic [ADDR_W-1:0] cs_waddr,
  input  logic [40:0]       cs_wdata,
  output logic [27:0]       mir,
  output logic [ADDR_W-1:0] mpc,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  ucount
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Control store: no reset, contents survive reset_n.
  logic [40:0]       store_q [DEPTH];

  state_e            state_q;
  logic [40:0]       mir_q;
  logic [ADDR_W-1:0] mpc_q;
  logic [CNT_W-1:0]  ucount_q;
  logic              running_q;
  logic              halted_q;

  // Decoded fields of the word currently held in the MIR.
  logic              halt_f;
  logic [8:0]        next_f;
  logic              jmpc_f;
  logic              jamn_f;
  logic              jamz_f;

  assign halt_f = mir_q[40];
  assign next_f = mir_q[39:31];
  assign jmpc_f = mir_q[30];
  assign jamn_f = mir_q[29];
  assign jamz_f = mir_q[28];

  // Interface handshake: there is no valid/ready pair. `start` and `cs_we`
  // are level requests sampled on each rising edge, and only take effect
  // outside RUN. When both are high on the same edge the write wins and the
  // start request is dropped, so a host can always patch the store safely.
  logic stopped;
  logic cs_write;
  logic load_start;

  assign stopped    = (state_q != ST_RUN);
  assign cs_write   = cs_we & stopped;
  assign load_start = start & ~cs_we & stopped;

  // Next microaddress. JAMN/JAMZ force the top bit; JMPC ORs the MBR byte
  // into the low eight bits, so next_addr normally has those bits clear to
  // act as a dispatch-table base.
  logic [8:0]        na9;
  logic [ADDR_W-1:0] mpc_d;

  always_comb begin
    na9 = next_f;
    if ((jamn_f & flag_n) | (jamz_f & flag_z)) begin
      na9[8] = 1'b1;
    end
    if (jmpc_f) begin
      na9[7:0] = na9[7:0] | mbr_byte;
    end
    mpc_d = ADDR_W'(na9);
  end

  // Synchronous write port. Writes are blocked in RUN, so a fetch can never
  // collide with a write to the same address.
  always_ff @(posedge clock) begin
    if (cs_write) begin
      store_q[cs_waddr] <= cs_wdata;
    end
  end

  // Sequencer FSM. The MIR register doubles as the synchronous read port of
  // the store: it is loaded with the word at the address being moved into
  // MPC, so the pipeline issues one word per cycle with no bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      mir_q     <= '0;
      mpc_q     <= '0;
      ucount_q  <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (load_start) begin
            state_q   <= ST_RUN;
            mpc_q     <= START_A;
            mir_q     <= store_q[START_A];
            running_q <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Every RUN edge retires the word on `mir`, including a halting one.
          ucount_q <= ucount_q + CNT_W'(1);
          if (halt_f) begin
            // MIR and MPC hold so the halting word stays inspectable.
            state_q   <= ST_HALT;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
          end else begin
            mpc_q <= mpc_d;
            mir_q <= store_q[mpc_d];
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  // Outside RUN the datapath sees an all-zero NOP.
  assign mir     = running_q ? mir_q[27:0] : 28'h0;
  assign mpc     = mpc_q;
  assign running = running_q;
  assign halted  = halted_q;
  assign ucount  = ucount_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer
//
// Directed bench for micro_sequencer. Expected {running, halted, mpc, mir}
// tuples are queued as stimulus is applied and popped one per clock.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

  localparam int ADDR_W = 9;
  localparam int CNT_W  = 32;
  localparam int EXP_W  = 39;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic              flag_n;
  logic              flag_z;
  logic [7:0]        mbr_byte;
  logic              cs_we;
  logic [ADDR_W-1:0] cs_waddr;
  logic [40:0]       cs_wdata;
  logic [27:0]       mir;
  logic [ADDR_W-1:0] mpc;
  logic              running;
  logic              halted;
  logic [CNT_W-1:0]  ucount;

  always #5 clock = ~clock;

  micro_sequencer #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (0),
    .CNT_W      (CNT_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .mbr_byte (mbr_byte),
    .cs_we    (cs_we),
    .cs_waddr (cs_waddr),
    .cs_wdata (cs_wdata),
    .mir      (mir),
    .mpc      (mpc),
    .running  (running),
    .halted   (halted),
    .ucount   (ucount)
  );

  // ---------------- scoreboard ----------------
  int               n_vec = 0;
  int               n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [40:0] cs_word(input logic h, input logic [8:0] na,
                                          input logic jm, input logic jn,
                                          input logic jz, input logic [27:0] dp);
    return {h, na, jm, jn, jz, dp};
  endfunction

  function automatic logic [27:0] halt_dp(input logic [8:0] a);
    return 28'hA00_0000 | {19'h0, a};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_cs(input logic [8:0] a, input logic [40:0] w);
    cs_we    = 1'b1;
    cs_waddr = a;
    cs_wdata = w;
    step();
    cs_we    = 1'b0;
  endtask

  task automatic push_exp(input logic [27:0] m, input logic [8:0] p,
                          input logic r, input logic h);
    exp_q.push_back({r, h, p, m});
  endtask

  task automatic step_check(input string tag);
    logic [EXP_W-1:0] e;
    step();
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no expected entry queued", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_mir"},  64'(mir),     64'(e[27:0]));
      check_eq({tag, "_mpc"},  64'(mpc),     64'(e[36:28]));
      check_eq({tag, "_run"},  64'(running), 64'(e[38]));
      check_eq({tag, "_halt"}, 64'(halted),  64'(e[37]));
    end
  endtask

  // Reset pulse of 3 ns placed between clock edges; outputs must clear
  // while reset_n is still low.
  task automatic async_reset(input string tag);
    #1 reset_n = 1'b0;
    #1;
    check_eq({tag, "_mir"},    64'(mir),     64'h0);
    check_eq({tag, "_mpc"},    64'(mpc),     64'h0);
    check_eq({tag, "_ucount"}, 64'(ucount),  64'h0);
    check_eq({tag, "_run"},    64'(running), 64'h0);
    check_eq({tag, "_halt"},   64'(halted),  64'h0);
    #2 reset_n = 1'b1;
    step();
  endtask

  // Loads word0 at address 0, runs it once and expects the branch to land
  // on exp_mpc, whose word must be a halt word carrying exp_dp1.
  task automatic run_branch(input string tag, input logic [40:0] w0,
                            input logic fn, input logic fz, input logic [7:0] mb,
                            input logic [8:0] exp_mpc, input logic [27:0] exp_dp1);
    write_cs(9'h000, w0);
    push_exp(w0[27:0], 9'h000, 1'b1, 1'b0);
    push_exp(exp_dp1,  exp_mpc, 1'b1, 1'b0);
    push_exp(28'h0,    exp_mpc, 1'b0, 1'b1);
    flag_n   = fn;
    flag_z   = fz;
    mbr_byte = mb;
    start    = 1'b1;
    step_check({tag, "_w0"});
    start    = 1'b0;
    step_check({tag, "_w1"});
    step_check({tag, "_hlt"});
    flag_n   = 1'b0;
    flag_z   = 1'b0;
    mbr_byte = 8'h00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    flag_n   = 1'b0;
    flag_z   = 1'b0;
    mbr_byte = 8'h00;
    cs_we    = 1'b0;
    cs_waddr = '0;
    cs_wdata = '0;

    // Reset state.
    #1;
    check_eq("rst_mir",    64'(mir),     64'h0);
    check_eq("rst_mpc",    64'(mpc),     64'h0);
    check_eq("rst_ucount", 64'(ucount),  64'h0);
    check_eq("rst_run",    64'(running), 64'h0);
    check_eq("rst_halt",   64'(halted),  64'h0);
    #2 reset_n = 1'b1;
    step();

    // Basic two-word program ending in halt.
    write_cs(9'h000, cs_word(1'b0, 9'h001, 1'b0, 1'b0, 1'b0, 28'h000_0011));
    write_cs(9'h001, cs_word(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 28'h123_4567));
    push_exp(28'h000_0011, 9'h000, 1'b1, 1'b0);
    push_exp(28'h123_4567, 9'h001, 1'b1, 1'b0);
    push_exp(28'h0,        9'h001, 1'b0, 1'b1);
    start = 1'b1;
    step_check("basic0");
    start = 1'b0;
    step_check("basic1");
    step_check("basic_hlt");
    check_eq("basic_ucount", 64'(ucount), 64'd2);

    // Halt words at every branch target used below.
    write_cs(9'h105, cs_word(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, halt_dp(9'h105)));
    write_cs(9'h005, cs_word(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, halt_dp(9'h005)));
    write_cs(9'h13C, cs_word(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, halt_dp(9'h13C)));
    write_cs(9'h0FF, cs_word(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, halt_dp(9'h0FF)));

    // JAMZ / JAMN.
    run_branch("jamz1", cs_word(1'b0, 9'h005, 1'b0, 1'b0, 1'b1, 28'h0B0_0001),
               1'b0, 1'b1, 8'h00, 9'h105, halt_dp(9'h105));
    run_branch("jamz0", cs_word(1'b0, 9'h005, 1'b0, 1'b0, 1'b1, 28'h0B0_0002),
               1'b0, 1'b0, 8'h00, 9'h005, halt_dp(9'h005));
    run_branch("jamn1", cs_word(1'b0, 9'h005, 1'b0, 1'b1, 1'b0, 28'h0B0_0003),
               1'b1, 1'b0, 8'h00, 9'h105, halt_dp(9'h105));
    run_branch("jamz_nf", cs_word(1'b0, 9'h005, 1'b0, 1'b0, 1'b1, 28'h0B0_0004),
               1'b1, 1'b0, 8'h00, 9'h005, halt_dp(9'h005));
    run_branch("jamn_zf", cs_word(1'b0, 9'h005, 1'b0, 1'b1, 1'b0, 28'h0B0_0005),
               1'b0, 1'b1, 8'h00, 9'h005, halt_dp(9'h005));

    // JMPC dispatch.
    run_branch("jmpc3c", cs_word(1'b0, 9'h100, 1'b1, 1'b0, 1'b0, 28'h0B0_0006),
               1'b0, 1'b0, 8'h3C, 9'h13C, halt_dp(9'h13C));
    run_branch("jmpcff", cs_word(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 28'h0B0_0007),
               1'b0, 1'b0, 8'hFF, 9'h0FF, halt_dp(9'h0FF));
    run_branch("nojmpc", cs_word(1'b0, 9'h005, 1'b0, 1'b0, 1'b0, 28'h0B0_0008),
               1'b0, 1'b0, 8'hFF, 9'h005, halt_dp(9'h005));

    // Write during RUN is ignored; start+write in HALT only writes.
    write_cs(9'h002, cs_word(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 28'h0D0_0002));
    write_cs(9'h000, cs_word(1'b0, 9'h002, 1'b0, 1'b0, 1'b0, 28'h0D0_0000));
    push_exp(28'h0D0_0000, 9'h000, 1'b1, 1'b0);
    start = 1'b1;
    step_check("wr_run0");
    start    = 1'b0;
    cs_we    = 1'b1;
    cs_waddr = 9'h002;
    cs_wdata = cs_word(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 28'h0E0_0002);
    push_exp(28'h0D0_0002, 9'h002, 1'b1, 1'b0);
    step_check("wr_run1");
    cs_we = 1'b0;
    push_exp(28'h0, 9'h002, 1'b0, 1'b1);
    step_check("wr_run_hlt");
    cs_we    = 1'b1;
    cs_waddr = 9'h000;
    cs_wdata = cs_word(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 28'h0E0_0000);
    start    = 1'b1;
    push_exp(28'h0, 9'h002, 1'b0, 1'b1);
    step_check("st_we_hlt");
    cs_we = 1'b0;
    push_exp(28'h0E0_0000, 9'h000, 1'b1, 1'b0);
    step_check("restart_new");
    start = 1'b0;
    push_exp(28'h0, 9'h000, 1'b0, 1'b1);
    step_check("restart_hlt");
    run_branch("wr_ignored", cs_word(1'b0, 9'h002, 1'b0, 1'b0, 1'b0, 28'h0D0_0000),
               1'b0, 1'b0, 8'h00, 9'h002, 28'h0D0_0002);

    // Self-loop at address 7 for 1000 cycles, with a stray start mid-way.
    async_reset("pre_loop_rst");
    write_cs(9'h000, cs_word(1'b0, 9'h007, 1'b0, 1'b0, 1'b0, 28'h0C0_0000));
    write_cs(9'h007, cs_word(1'b0, 9'h007, 1'b0, 1'b0, 1'b0, 28'h0C0_0007));
    push_exp(28'h0C0_0000, 9'h000, 1'b1, 1'b0);
    start = 1'b1;
    step_check("loop_start");
    start = 1'b0;
    check_eq("loop_ucount0", 64'(ucount), 64'd0);
    for (int i = 0; i < 1000; i++) begin
      start  = (i == 500);
      flag_n = $urandom_range(0, 1);
      flag_z = $urandom_range(0, 1);
      push_exp(28'h0C0_0007, 9'h007, 1'b1, 1'b0);
      step_check("loop");
    end
    start  = 1'b0;
    flag_n = 1'b0;
    flag_z = 1'b0;
    check_eq("loop_ucount", 64'(ucount), 64'd1000);

    // Reset mid-RUN, then confirm the store survived it.
    async_reset("mid_run_rst");
    push_exp(28'h0C0_0000, 9'h000, 1'b1, 1'b0);
    start = 1'b1;
    step_check("post_rst0");
    start = 1'b0;
    push_exp(28'h0C0_0007, 9'h007, 1'b1, 1'b0);
    step_check("post_rst1");
    check_eq("post_rst_ucount", 64'(ucount), 64'd1);
    async_reset("final_rst");

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
